vpu_operand_fetch_unit: RTL and testbench

- Upstream neighbour of the lane/write-back path.
- On start, issues one SRAM read for a source operand row and captures the returned row.
- Slices the row into EXEC_UNIT_DATA_WIDTH elements and streams them to the execution lane with a valid/ready handshake.
- Signals done to the VPU controller when the last element is accepted, so the lane can produce the element stream that the write-back unit packs back into a row.

---
 rtl/vpu_operand_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_vpu_operand_fetch_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_operand_fetch_unit.sv
// Operand fetch: reads one SRAM row per start, then streams it to the lane as
// EXEC_UNIT_DATA_WIDTH elements (element 0 = row LSBs) over valid/ready.
module vpu_operand_fetch_unit #(
    parameter int SRAM_DATA_WIDTH      = 256,
    parameter int EXEC_UNIT_DATA_WIDTH = 32,
    parameter int EXEC_CNT             = SRAM_DATA_WIDTH / EXEC_UNIT_DATA_WIDTH,
    parameter int OPERAND_ADDR_WIDTH   = 16,
    parameter int BANK_ID_WIDTH        = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start_i,
    input  logic [OPERAND_ADDR_WIDTH-1:0]              src_addr_i,
    input  logic [$clog2(EXEC_CNT):0]                  elem_cnt_i,
    output logic                                       done_o,
    output logic                                       sram_req_o,
    input  logic                                       sram_ack_i,
    output logic [BANK_ID_WIDTH-1:0]                   sram_rid_o,
    output logic [OPERAND_ADDR_WIDTH-BANK_ID_WIDTH-1:0] sram_addr_o,
    input  logic                                       sram_rvalid_i,
    input  logic [SRAM_DATA_WIDTH-1:0]                 sram_rdata_i,
    output logic                                       op_valid_o,
    input  logic                                       op_ready_i,
    output logic [EXEC_UNIT_DATA_WIDTH-1:0]            op_data_o,
    output logic                                       op_last_o
);

    localparam int IDX_W = $clog2(EXEC_CNT);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(EXEC_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT   = 2'd2,
        S_STREAM = 2'd3
    } state_t;

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic [OPERAND_ADDR_WIDTH-1:0]     r_addr;
    logic [CNT_W-1:0]                  r_cnt;
    logic [IDX_W-1:0]                  r_idx;
    logic [SRAM_DATA_WIDTH-1:0]        r_row;
    logic                              w_start_acc;
    logic                              w_row_load;
    logic                              w_xfer;
    logic                              w_last;
    logic [EXEC_UNIT_DATA_WIDTH-1:0]   w_elems [EXEC_CNT];

    // Out-of-range counts (0 or above EXEC_CNT) mean "whole row".
    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
        if ((c == '0) || (c > CNT_MAX)) begin
            return CNT_MAX;
        end
        return c;
    endfunction

    for (genvar g = 0; g < EXEC_CNT; g++) begin : g_slice
        assign w_elems[g] = r_row[g*EXEC_UNIT_DATA_WIDTH +: EXEC_UNIT_DATA_WIDTH];
    end

    assign w_last      = (r_state == S_STREAM) && (CNT_W'(r_idx) == (r_cnt - CNT_ONE));
    assign sram_rid_o  = r_addr[BANK_ID_WIDTH-1:0];
    assign sram_addr_o = r_addr[OPERAND_ADDR_WIDTH-1:BANK_ID_WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_row_load  = 1'b0;
        w_xfer      = 1'b0;
        done_o      = 1'b0;
        sram_req_o  = 1'b0;
        op_valid_o  = 1'b0;
        op_last_o   = 1'b0;
        op_data_o   = '0;
        case (r_state)
            S_IDLE: begin
                done_o = 1'b1;
                if (start_i) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                sram_req_o = 1'b1;
                // Data may return in the accept cycle itself; skip S_WAIT then.
                if (sram_ack_i) begin
                    if (sram_rvalid_i) begin
                        w_row_load  = 1'b1;
                        w_state_nxt = S_STREAM;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (sram_rvalid_i) begin
                    w_row_load  = 1'b1;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                op_valid_o = 1'b1;
                op_last_o  = w_last;
                op_data_o  = w_elems[r_idx];
                if (op_ready_i) begin
                    w_xfer = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_addr <= src_addr_i;
                r_cnt  <= sat_cnt(elem_cnt_i);
            end
            if (w_row_load) begin
                r_row <= sram_rdata_i;
            end
            if (w_xfer) begin
                r_idx <= w_last ? '0 : (r_idx + IDX_ONE);
            end
        end
    end

endmodule

// File: tb/tb_vpu_operand_fetch_unit.sv
// Directed bench for vpu_operand_fetch_unit: fetch handshake timing, element
// streaming under backpressure, count saturation and reset mid-stream.
module tb_vpu_operand_fetch_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [15:0]  src_addr_i;
    logic [3:0]   elem_cnt_i;
    logic         done_o;
    logic         sram_req_o;
    logic         sram_ack_i;
    logic [1:0]   sram_rid_o;
    logic [13:0]  sram_addr_o;
    logic         sram_rvalid_i;
    logic [255:0] sram_rdata_i;
    logic         op_valid_o;
    logic         op_ready_i;
    logic [31:0]  op_data_o;
    logic         op_last_o;

    int checks = 0;
    int fails  = 0;

    logic [255:0] row_a;
    logic [255:0] row_b;

    vpu_operand_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .src_addr_i    (src_addr_i),
        .elem_cnt_i    (elem_cnt_i),
        .done_o        (done_o),
        .sram_req_o    (sram_req_o),
        .sram_ack_i    (sram_ack_i),
        .sram_rid_o    (sram_rid_o),
        .sram_addr_o   (sram_addr_o),
        .sram_rvalid_i (sram_rvalid_i),
        .sram_rdata_i  (sram_rdata_i),
        .op_valid_o    (op_valid_o),
        .op_ready_i    (op_ready_i),
        .op_data_o     (op_data_o),
        .op_last_o     (op_last_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_done"},  64'(done_o),     64'd1);
        chk({tag, "_req"},   64'(sram_req_o), 64'd0);
        chk({tag, "_valid"}, 64'(op_valid_o), 64'd0);
        chk({tag, "_last"},  64'(op_last_o),  64'd0);
        chk({tag, "_data"},  64'(op_data_o),  64'd0);
    endtask

    task automatic do_start(input logic [15:0] addr, input logic [3:0] cnt);
        start_i    = 1'b1;
        src_addr_i = addr;
        elem_cnt_i = cnt;
        tick();
        start_i    = 1'b0;
        src_addr_i = 16'hFFFF;
        chk("start_req",  64'(sram_req_o), 64'd1);
        chk("start_done", 64'(done_o),     64'd0);
        chk("start_rid",  64'(sram_rid_o), 64'(addr[1:0]));
        chk("start_addr", 64'(sram_addr_o), 64'(addr[15:2]));
    endtask

    // ack_dly idle cycles of req before ack; rv_dly cycles from ack to rvalid (0 = same cycle)
    task automatic fetch(input int ack_dly, input int rv_dly, input logic [255:0] row);
        for (int i = 0; i < ack_dly; i++) begin
            chk("wait_ack_req",   64'(sram_req_o), 64'd1);
            chk("wait_ack_valid", 64'(op_valid_o), 64'd0);
            tick();
        end
        sram_ack_i = 1'b1;
        if (rv_dly == 0) begin
            sram_rvalid_i = 1'b1;
            sram_rdata_i  = row;
        end
        tick();
        sram_ack_i    = 1'b0;
        sram_rvalid_i = 1'b0;
        sram_rdata_i  = '1;
        chk("post_ack_req", 64'(sram_req_o), 64'd0);
        if (rv_dly > 0) begin
            for (int i = 0; i < rv_dly - 1; i++) begin
                chk("wait_rv_valid", 64'(op_valid_o), 64'd0);
                chk("wait_rv_req",   64'(sram_req_o), 64'd0);
                tick();
            end
            chk("wait_rv_valid", 64'(op_valid_o), 64'd0);
            sram_rvalid_i = 1'b1;
            sram_rdata_i  = row;
            tick();
            sram_rvalid_i = 1'b0;
            sram_rdata_i  = '1;
        end
    endtask

    // rdy_pat bit c gives ready in stream cycle c (cycled over patlen; patlen 0 = always ready)
    task automatic stream(input string tag, input int n, input logic [255:0] row,
                          input logic [31:0] rdy_pat, input int patlen, input int start_at);
        int idx = 0;
        int cyc = 0;
        logic rdy;
        while (idx < n && cyc < 64) begin
            rdy        = (patlen == 0) ? 1'b1 : rdy_pat[cyc % patlen];
            op_ready_i = rdy;
            start_i    = (cyc == start_at);
            chk({tag, "_valid"}, 64'(op_valid_o), 64'd1);
            chk({tag, "_done"},  64'(done_o),     64'd0);
            chk({tag, "_data"},  64'(op_data_o),  64'(row[idx*32 +: 32]));
            chk({tag, "_last"},  64'(op_last_o),  64'(idx == n - 1));
            tick();
            if (rdy) idx++;
            cyc++;
        end
        op_ready_i = 1'b0;
        start_i    = 1'b0;
        chk({tag, "_count"}, 64'(idx), 64'(n));
        chk_idle({tag, "_end"});
        tick();
        chk({tag, "_noreq"}, 64'(sram_req_o), 64'd0);
    endtask

    initial begin
        rst           = 1'b1;
        start_i       = 1'b0;
        src_addr_i    = '0;
        elem_cnt_i    = '0;
        sram_ack_i    = 1'b0;
        sram_rvalid_i = 1'b0;
        sram_rdata_i  = '1;
        op_ready_i    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            row_a[k*32 +: 32] = 32'(k);
            row_b[k*32 +: 32] = 32'hA500_0000 + 32'(k * 32'h11);
        end
        tick();
        tick();
        rst = 1'b0;
        chk_idle("reset");
        chk("reset_rid",  64'(sram_rid_o),  64'd0);
        chk("reset_addr", 64'(sram_addr_o), 64'd0);

        // Case 2: immediate ack, rvalid next cycle, full row with ready high
        do_start(16'h0015, 4'd8);
        fetch(0, 1, row_a);
        stream("c2", 8, row_a, 32'd0, 0, -1);

        // Case 3: delayed ack and rvalid
        do_start(16'h1236, 4'd8);
        fetch(4, 3, row_a);
        stream("c3", 8, row_a, 32'd0, 0, -1);

        // Case 4: three elements with ready pattern 1,0,0,1,1
        do_start(16'h0042, 4'd3);
        fetch(0, 1, row_b);
        stream("c4", 3, row_b, 32'b11001, 5, -1);

        // Case 5: saturating counts, stray start during streaming
        do_start(16'h0100, 4'd0);
        fetch(1, 2, row_b);
        stream("c5_zero", 8, row_b, 32'd0, 0, 2);
        do_start(16'h0203, 4'd9);
        fetch(0, 1, row_a);
        stream("c5_nine", 8, row_a, 32'b110, 3, 4);

        // Case 6: ack and rvalid together
        do_start(16'h0007, 4'd8);
        fetch(0, 0, row_b);
        chk("c6_first_valid", 64'(op_valid_o), 64'd1);
        chk("c6_first_data",  64'(op_data_o),  64'(row_b[31:0]));
        stream("c6", 8, row_b, 32'd0, 0, -1);

        // Case 1b: reset in the middle of streaming at idx 3
        do_start(16'h00F1, 4'd8);
        fetch(0, 1, row_a);
        op_ready_i = 1'b1;
        tick();
        tick();
        tick();
        op_ready_i = 1'b0;
        chk("rst_mid_data", 64'(op_data_o), 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("rst_mid");
        chk("rst_mid_rid",  64'(sram_rid_o),  64'd0);
        chk("rst_mid_addr", 64'(sram_addr_o), 64'd0);
        tick();
        chk("rst_mid_noreq", 64'(sram_req_o), 64'd0);

        // Stream restarts from element 0 after reset
        do_start(16'h0015, 4'd2);
        fetch(0, 1, row_b);
        stream("post_rst", 2, row_b, 32'd0, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
